// File: rtl/register_file_sb_if.sv
// Register file bus: two read ports, one write port, reservation port and busy status.
interface register_file_sb_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] read_reg1;
   logic [ADDR_W-1:0] read_reg2;
   logic [DATA_W-1:0] read_data1;
   logic [DATA_W-1:0] read_data2;
   logic              busy1;
   logic              busy2;
   logic              reg_write;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_reg;
   logic              rsv_ok;
   logic [ADDR_W:0]   busy_count;

   modport master (
      output read_reg1, read_reg2, reg_write, write_reg, write_data, rsv_en, rsv_reg,
      input  read_data1, read_data2, busy1, busy2, rsv_ok, busy_count
   );

   modport slave (
      input  read_reg1, read_reg2, reg_write, write_reg, write_data, rsv_en, rsv_reg,
      output read_data1, read_data2, busy1, busy2, rsv_ok, busy_count
   );
endinterface

// File: rtl/register_file_sb.sv
// 2-read/1-write register file with write-to-read bypass, optional zero register
// and a per-register busy scoreboard for multicycle write-backs.
module register_file_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input logic               clk,
   input logic               rst,
   register_file_sb_if.slave bus
);
   localparam int unsigned NUM_REGS = 2 ** ADDR_W;
   localparam int unsigned CNT_W    = ADDR_W + 1;

   logic [DATA_W-1:0]   mem [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [CNT_W-1:0]    count;

   logic              wr_zero;
   logic              wr_en;
   logic              rsv_zero;
   logic              rsv_ok;
   logic              rsv_set;
   logic              cnt_inc;
   logic              cnt_dec;
   logic              wb_hit1;
   logic              wb_hit2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   // Write qualification, bypass matches and scoreboard decisions
   always_comb begin
      wr_zero  = (ZERO_REG != 0) && (bus.write_reg == '0);
      rsv_zero = (ZERO_REG != 0) && (bus.rsv_reg == '0);
      wr_en    = bus.reg_write && !wr_zero;
      wb_hit1  = bus.reg_write && (bus.write_reg == bus.read_reg1);
      wb_hit2  = bus.reg_write && (bus.write_reg == bus.read_reg2);
      rsv_ok   = bus.rsv_en && (rsv_zero || !busy[bus.rsv_reg] ||
                                (bus.reg_write && (bus.write_reg == bus.rsv_reg)));
      rsv_set  = rsv_ok && !rsv_zero;
      // Count tracks actual bit transitions so a same-register clear+set nets zero.
      cnt_inc  = rsv_set && !busy[bus.rsv_reg];
      cnt_dec  = bus.reg_write && busy[bus.write_reg] &&
                 !(rsv_set && (bus.rsv_reg == bus.write_reg));
   end

   // Read ports: array read, then bypass, then zero-register override
   always_comb begin
      rd1 = mem[bus.read_reg1];
      rd2 = mem[bus.read_reg2];
      if ((BYPASS != 0) && wr_en && wb_hit1) rd1 = bus.write_data;
      if ((BYPASS != 0) && wr_en && wb_hit2) rd2 = bus.write_data;
      if ((ZERO_REG != 0) && (bus.read_reg1 == '0)) rd1 = '0;
      if ((ZERO_REG != 0) && (bus.read_reg2 == '0)) rd2 = '0;
   end

   // Register array, busy bits and reservation count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) mem[i] <= '0;
         busy  <= '0;
         count <= '0;
      end else begin
         if (wr_en) mem[bus.write_reg] <= bus.write_data;
         if (bus.reg_write) busy[bus.write_reg] <= 1'b0;
         if (rsv_set) busy[bus.rsv_reg] <= 1'b1;
         count <= count + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
      end
   end

   assign bus.read_data1 = rd1;
   assign bus.read_data2 = rd2;
   assign bus.busy1      = busy[bus.read_reg1] && !wb_hit1;
   assign bus.busy2      = busy[bus.read_reg2] && !wb_hit2;
   assign bus.rsv_ok     = rsv_ok;
   assign bus.busy_count = count;
endmodule
